// File: rtl/z80_mem_arbiter.sv
// Arbiter sharing one single-port memory between the Z80 bus and the video fetcher.
// Video has priority; a burst counter bounds how long a pending CPU access can be held off.
module z80_mem_arbiter #(
  parameter int MEM_LAT   = 2,
  parameter int VID_BURST = 1
) (
  input  logic        CLK_n,
  input  logic        RESET_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_clken,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  input  logic [7:0]  mem_q,
  output logic        mem_we,
  output logic        mem_oe
);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  localparam logic [2:0] LAST   = 3'(MEM_LAT - 1);
  localparam logic [1:0] VB_MAX = 2'(VID_BURST);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [1:0]  vburst_reg;
  logic        cpu_done_reg;
  logic        is_wr_reg;
  logic        vid_ack_reg;
  logic [7:0]  cpu_di_reg;
  logic [7:0]  vid_data_reg;
  logic [15:0] mem_a_reg;
  logic [7:0]  mem_d_reg;

  logic cpu_req;
  logic vid_win;
  logic last;

  // cpu_done masks a strobe that is still low after its access was served
  assign cpu_req = !cpu_mreq_n & cpu_rfsh_n & (!cpu_rd_n | !cpu_wr_n) & !cpu_done_reg;
  assign vid_win = vid_req & (!cpu_req | (vburst_reg < VB_MAX));
  assign last    = (cnt_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (vid_win)
          state_next = VID;
        else if (cpu_req)
          state_next = CPU;
      end
      VID, CPU: begin
        if (last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      vburst_reg   <= 2'd0;
      cpu_done_reg <= 1'b0;
      is_wr_reg    <= 1'b0;
      vid_ack_reg  <= 1'b0;
      cpu_di_reg   <= 8'd0;
      vid_data_reg <= 8'd0;
      mem_a_reg    <= 16'd0;
      mem_d_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      vid_ack_reg <= 1'b0;

      if (state_reg != IDLE && !last)
        cnt_reg <= cnt_reg + 3'd1;
      else
        cnt_reg <= 3'd0;

      if (state_reg == CPU && last)
        cpu_done_reg <= 1'b1;
      else if (cpu_mreq_n)
        cpu_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (vid_win) begin
            mem_a_reg  <= vid_addr;
            vburst_reg <= cpu_req ? vburst_reg + 2'd1 : 2'd0;
          end else if (cpu_req) begin
            // the access kind is frozen here so a dropped strobe cannot cancel it
            mem_a_reg  <= cpu_a;
            is_wr_reg  <= !cpu_wr_n;
            vburst_reg <= 2'd0;
            if (!cpu_wr_n)
              mem_d_reg <= cpu_do;
          end else begin
            vburst_reg <= 2'd0;
          end
        end
        VID: begin
          if (last) begin
            vid_data_reg <= mem_q;
            vid_ack_reg  <= 1'b1;
          end
        end
        CPU: begin
          if (last && !is_wr_reg)
            cpu_di_reg <= mem_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = (state_reg == CPU) & is_wr_reg;
  assign mem_oe    = (state_reg == VID) | ((state_reg == CPU) & !is_wr_reg);
  assign cpu_clken = RESET_n ? !cpu_req : 1'b1;
  assign cpu_di    = cpu_di_reg;
  assign vid_data  = vid_data_reg;
  assign vid_ack   = vid_ack_reg;
  assign mem_a     = mem_a_reg;
  assign mem_d     = mem_d_reg;

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed bench for z80_mem_arbiter: CPU read/write, contention, refresh, reset abort,
// and single-cycle-latency video streaming on a second instance.
module tb_z80_mem_arbiter;

  logic        clk = 1'b0;
  logic        RESET_n;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do, cpu_di;
  logic        cpu_clken;
  logic        vid_req, vid_ack;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic [15:0] mem_a;
  logic [7:0]  mem_d, mem_q;
  logic        mem_we, mem_oe;

  logic        vid_req1, vid_ack1, cpu_clken1, mem_we1, mem_oe1;
  logic [15:0] vid_addr1, mem_a1;
  logic [7:0]  vid_data1, cpu_di1, mem_d1, mem_q1;
  logic        idle_n = 1'b1;
  logic [15:0] zero16 = 16'd0;
  logic [7:0]  zero8 = 8'd0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  grants [$];
  logic [7:0]  exp_g [0:3];
  logic [7:0]  vexp [0:3];

  int compared = 0;
  int mismatched = 0;
  int clken_low_cnt = 0;
  int ack_cnt = 0;
  int we_cnt = 0;
  int oe_cnt = 0;
  logic prev_active = 1'b0;

  always #5 clk = ~clk;

  z80_mem_arbiter #(.MEM_LAT(2), .VID_BURST(1)) u_dut (
    .CLK_n(clk), .RESET_n(RESET_n),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_rfsh_n(cpu_rfsh_n),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di), .cpu_clken(cpu_clken),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  z80_mem_arbiter #(.MEM_LAT(1), .VID_BURST(1)) u_dut1 (
    .CLK_n(clk), .RESET_n(RESET_n),
    .cpu_mreq_n(idle_n), .cpu_rd_n(idle_n), .cpu_wr_n(idle_n), .cpu_rfsh_n(idle_n),
    .cpu_a(zero16), .cpu_do(zero8), .cpu_di(cpu_di1), .cpu_clken(cpu_clken1),
    .vid_req(vid_req1), .vid_addr(vid_addr1), .vid_ack(vid_ack1), .vid_data(vid_data1),
    .mem_a(mem_a1), .mem_d(mem_d1), .mem_q(mem_q1), .mem_we(mem_we1), .mem_oe(mem_oe1)
  );

  // asynchronous SRAM model; the arbiter keeps the address stable for the whole access
  assign mem_q  = mem[mem_a];
  assign mem_q1 = mem[mem_a1];

  always @(posedge clk)
    if (mem_we) mem[mem_a] <= mem_d;

  always @(negedge clk) begin
    logic active;
    active = mem_oe | mem_we;
    if (!cpu_clken) clken_low_cnt++;
    if (vid_ack) ack_cnt++;
    if (mem_we) we_cnt++;
    if (mem_oe) oe_cnt++;
    if (active && !prev_active)
      grants.push_back((mem_a[15:8] == 8'h20) ? 8'h56 : 8'h43);
    prev_active = active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    clken_low_cnt = 0;
    ack_cnt = 0;
    we_cnt = 0;
    oe_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_g[0] = 8'h56; exp_g[1] = 8'h43; exp_g[2] = 8'h56; exp_g[3] = 8'h43;
    vexp[0] = 8'h61; vexp[1] = 8'h72; vexp[2] = 8'h83; vexp[3] = 8'h94;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h4000] = 8'hA5; mem[16'h4001] = 8'h5A;
    mem[16'h2000] = 8'h11; mem[16'h2001] = 8'h22; mem[16'h2002] = 8'h33; mem[16'h2003] = 8'h44;
    mem[16'h3000] = 8'h61; mem[16'h3001] = 8'h72; mem[16'h3002] = 8'h83; mem[16'h3003] = 8'h94;

    RESET_n = 1'b0;
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_rfsh_n = 1'b1;
    cpu_a = 16'h0000; cpu_do = 8'h00;
    vid_req = 1'b0; vid_addr = 16'h0000;
    vid_req1 = 1'b0; vid_addr1 = 16'h0000;
    repeat (3) tick();
    check("rst_clken", cpu_clken, 1);
    check("rst_mem_a", mem_a, 16'h0000);
    check("rst_strobes", {mem_we, mem_oe, vid_ack}, 3'b000);
    check("rst_data", {cpu_di, vid_data, mem_d}, 24'h000000);
    RESET_n = 1'b1;
    tick();
    tick();

    // CPU read, uncontended; MREQ stays low two cycles past completion
    clr();
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1 check("rd_stall_start", cpu_clken, 0);
    repeat (5) tick();
    check("rd_cpu_di", cpu_di, 8'hA5);
    check("rd_clken_hold", cpu_clken, 1);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();
    check("rd_stall_cycles", clken_low_cnt, 3);
    check("rd_single_access", oe_cnt, 2);
    check("rd_no_we", we_cnt, 0);

    // CPU write held for five cycles; only one write may happen
    clr();
    cpu_a = 16'h8001; cpu_do = 8'h3C; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wr_we", mem_we, 1);
    check("wr_mem_a", mem_a, 16'h8001);
    check("wr_mem_d", mem_d, 8'h3C);
    tick(); tick(); tick(); tick();
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    tick(); tick();
    check("wr_we_cycles", we_cnt, 2);
    check("wr_stall_cycles", clken_low_cnt, 3);
    check("wr_mem_content", mem[16'h8001], 8'h3C);

    // video and CPU requests arrive together
    clr();
    grants.delete();
    vid_req = 1'b1; vid_addr = 16'h2000;
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    tick(); tick(); tick();
    check("ct_ack1", vid_ack, 1);
    check("ct_vdata1", vid_data, 8'h11);
    vid_addr = 16'h2001;
    tick(); tick(); tick();
    check("ct_cpu_di1", cpu_di, 8'hA5);
    check("ct_clken_back", cpu_clken, 1);
    check("ct_stall_cycles", clken_low_cnt, 6);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick(); tick();
    check("ct_ack2", vid_ack, 1);
    check("ct_vdata2", vid_data, 8'h22);
    vid_req = 1'b0;
    clr();
    cpu_a = 16'h4001; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    tick(); tick(); tick();
    check("ct_cpu_di2", cpu_di, 8'h5A);
    check("ct_stall2_cycles", clken_low_cnt, 3);
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();
    check("ct_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ct_grant%0d", i), (grants.size() > i) ? grants[i] : 8'h00, exp_g[i]);

    // refresh cycle with a concurrent video request
    clr();
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'b0;
    vid_req = 1'b1; vid_addr = 16'h2002;
    tick(); tick(); tick();
    check("rf_ack", vid_ack, 1);
    check("rf_vdata", vid_data, 8'h33);
    vid_req = 1'b0;
    cpu_mreq_n = 1'b1; cpu_rfsh_n = 1'b1; cpu_rd_n = 1'b1;
    tick(); tick();
    check("rf_clken_low", clken_low_cnt, 0);
    check("rf_no_we", we_cnt, 0);
    check("rf_grant_count", grants.size(), 5);
    check("rf_grant_vid", (grants.size() > 4) ? grants[4] : 8'h00, 8'h56);

    // reset asserted in the second VID cycle
    vid_req = 1'b1; vid_addr = 16'h2003;
    tick(); tick();
    RESET_n = 1'b0;
    #1;
    check("ra_mem_oe", mem_oe, 0);
    check("ra_mem_a", mem_a, 16'h0000);
    check("ra_vid", {vid_ack, vid_data}, 9'h000);
    check("ra_cpu_di", cpu_di, 8'h00);
    check("ra_clken", cpu_clken, 1);
    clr();
    @(posedge clk);
    #3 RESET_n = 1'b1;
    tick();
    check("ra_fresh_oe", mem_oe, 1);
    check("ra_fresh_a", mem_a, 16'h2003);
    tick(); tick();
    check("ra_ack", vid_ack, 1);
    check("ra_vdata", vid_data, 8'h44);
    check("ra_no_early_ack", ack_cnt, 0);
    vid_req = 1'b0;
    tick();
    check("ra_ack_once", ack_cnt, 1);

    // single-cycle latency video stream on the second instance
    vid_req1 = 1'b1; vid_addr1 = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("l1_gap%0d", i), vid_ack1, 0);
      check($sformatf("l1_oe%0d", i), mem_oe1, 1);
      tick();
      check($sformatf("l1_ack%0d", i), vid_ack1, 1);
      check($sformatf("l1_vdata%0d", i), vid_data1, vexp[i]);
      vid_addr1 = vid_addr1 + 16'd1;
      if (i == 3) vid_req1 = 1'b0;
    end
    check("l1_cpu_side", {cpu_clken1, mem_we1, cpu_di1, mem_d1}, 18'h20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/z80_mem_arbiter.md
Name: z80_mem_arbiter

Overview:
- Shares one single-port memory (SRAM/BRAM) between the Z80 CPU bus and the video fetcher.
- Sequences every access through a small FSM. Stalls the CPU through its clock-enable until the CPU's own access completes.
- Sits between the CPU wrapper (MREQ_n/RD_n/WR_n/RFSH_n/A/DO/DI/CLKEN) and the memory macro. Video has priority, but fairness rules prevent CPU starvation.

Parameters:
- MEM_LAT, 2: cycles per memory access (legal 1..7); the address and data stay stable for the whole access.
- VID_BURST, 1: maximum consecutive video grants while a CPU request is pending (legal 1..3).

Ports:
- CLK_n  in  1  system clock; all flops on rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- cpu_mreq_n  in  1  CPU memory request.
- cpu_rd_n  in  1  CPU read strobe.
- cpu_wr_n  in  1  CPU write strobe.
- cpu_rfsh_n  in  1  CPU refresh; a refresh cycle generates no memory access.
- cpu_a  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  registered read data to the CPU.
- cpu_clken  out  1  CPU clock enable; 0 stalls the CPU.
- vid_req  in  1  video fetch request (level; held until vid_ack).
- vid_addr  in  16  video fetch address.
- vid_ack  out  1  one-cycle pulse; vid_data is valid in the same cycle.
- vid_data  out  8  registered video read data.
- mem_a  out  16  memory address.
- mem_d  out  8  memory write data.
- mem_q  in  8  memory read data, valid MEM_LAT cycles after the address is presented.
- mem_we  out  1  memory write enable.
- mem_oe  out  1  memory output enable.

Behaviour:
- cpu_req (combinational) = !cpu_mreq_n & cpu_rfsh_n & (!cpu_rd_n | !cpu_wr_n) & !cpu_done.
- cpu_done:
  - Set when a CPU access completes.
  - Cleared in the cycle after cpu_mreq_n is sampled high.
  - Prevents a still-asserted strobe from being served twice.
- cpu_clken = RESET_n ? !cpu_req : 1.
  - The CPU stalls from the first cycle its request is seen until the cycle after completion.
  - A stalled CPU holds its address, data and strobes stable.
- FSM states: IDLE, VID, CPU. A cnt register (3 bits) counts access cycles. vburst (2 bits) counts consecutive video grants made while cpu_req is pending.
- Transitions from IDLE:
  - vid_req & (!cpu_req | vburst < VID_BURST) -> VID, vburst += cpu_req.
  - else cpu_req -> CPU, vburst = 0.
  - else remain in IDLE.
  - Arbitration is decided in IDLE only.
- VID state:
  - mem_a = vid_addr latched at entry; mem_oe = 1.
  - At cnt == MEM_LAT-1: vid_data <= mem_q, vid_ack = 1 for one cycle, go to IDLE.
- CPU state:
  - mem_a = cpu_a. For a write: mem_d = cpu_do and mem_we = 1 on every CPU-state cycle. For a read: mem_oe = 1.
  - At cnt == MEM_LAT-1: for a read, cpu_di <= mem_q; cpu_done <= 1; go to IDLE.
- Latency:
  - An uncontended CPU access takes 1 (IDLE decision) + MEM_LAT cycles of cpu_clken = 0.
  - Worst case adds VID_BURST*(MEM_LAT+1) cycles.
- Simultaneous events:
  - vid_req & cpu_req with vburst < VID_BURST: video wins.
  - Once vburst == VID_BURST: the CPU wins.
  - vburst is cleared whenever cpu_req is low in IDLE.
- Strobe behaviour:
  - A request that drops mid-access (not legal while stalled) still completes; the write is not cancelled.
  - cpu_rd_n and cpu_wr_n both low is treated as a write.
- Idle outputs (any non-access cycle): mem_we = 0, mem_oe = 0. mem_a and mem_d hold their last values.
- Reset values:
  - FSM = IDLE; cnt, vburst and cpu_done = 0.
  - vid_ack, mem_we, mem_oe = 0.
  - cpu_di, vid_data, mem_a, mem_d = 0.
  - cpu_clken = 1.
- Reset mid-access aborts immediately; no ack or done is produced. A request still asserted after reset is served from scratch.

Test Plan:
- CPU read, MEM_LAT=2, mem[0x4000]=0xA5, no video:
  - cpu_clken low for exactly 3 cycles.
  - cpu_di=0xA5, mem_we never asserted.
  - Single access only, although MREQ stays low for 2 further cycles.
- CPU write 0x3C to 0x8001:
  - mem_we high for 2 cycles with mem_a=0x8001, mem_d=0x3C.
  - cpu_done holds off a second write until cpu_mreq_n rises.
- vid_req and cpu_req rise in the same cycle, VID_BURST=1, vid_req held continuously:
  - Grant order is VID, CPU, VID, CPU.
  - vid_ack pulses once per VID grant.
  - CPU stall is 6 cycles.
- Refresh cycle (cpu_mreq_n=0, cpu_rfsh_n=0):
  - No memory access and cpu_clken stays 1.
  - A concurrent vid_req is served normally.
- RESET_n pulsed low in the 2nd VID cycle:
  - All outputs go to reset values asynchronously; no vid_ack.
  - After release with vid_req still high, a fresh VID access of MEM_LAT cycles completes.
- MEM_LAT=1, back-to-back video requests:
  - vid_ack every 2 cycles.
  - vid_data tracks mem_q from the correct address each time.
